// File: rtl/jtag_l2_pkg.sv
// Shared types and constants for the JTAG-to-L2 SRAM bridge.
package jtag_l2_pkg;

    localparam int unsigned L2_WORD_BYTES = 4;
    localparam int unsigned L2_DATA_W     = 32;
    localparam int unsigned L2_ADDR_W     = 32;
    localparam int unsigned L2_BE_W       = L2_WORD_BYTES;

    typedef struct packed {
        logic                 err;
        logic [L2_DATA_W-1:0] rdata;
    } l2_resp_t;

    // Reads always fetch the whole word; writes honour the caller's byte enables.
    function automatic logic [L2_BE_W-1:0] l2_strobe_be(input logic we,
                                                         input logic [L2_BE_W-1:0] be);
        return we ? be : {L2_BE_W{1'b1}};
    endfunction

endpackage

// File: rtl/jtag_l2_mem_bridge_if.sv
// Request/grant plus valid/ready response bus between the JTAG bus master and the L2 bridge.
interface jtag_l2_mem_bridge_if;
    import jtag_l2_pkg::*;

    logic                 req_i;
    logic                 gnt_o;
    logic [L2_ADDR_W-1:0] addr_i;
    logic                 we_i;
    logic [L2_BE_W-1:0]   be_i;
    logic [L2_DATA_W-1:0] wdata_i;
    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [L2_DATA_W-1:0] r_rdata_o;
    logic                 r_err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, r_ready_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, r_ready_i,
        output gnt_o, r_valid_o, r_rdata_o, r_err_o
    );

endinterface

// File: rtl/jtag_l2_resp_fifo.sv
// In-order response FIFO of l2_resp_t; head is forced to zero while empty.
module jtag_l2_resp_fifo
    import jtag_l2_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_n,
    input  logic     push,
    input  l2_resp_t push_data,
    input  logic     pop,
    output l2_resp_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    l2_resp_t      store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage carries no reset; emptiness masks stale entries.
    always_ff @(posedge clk_i) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/jtag_l2_mem_bridge.sv
// JTAG bus master to single-port L2 SRAM bridge: address decode, SRAM strobes,
// one-cycle pending stage and a credit-limited in-order response FIFO.
module jtag_l2_mem_bridge
    import jtag_l2_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    jtag_l2_mem_bridge_if.slave          bus,
    output logic                         mem_csn_o,
    output logic                         mem_wen_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [L2_BE_W-1:0]           mem_be_o,
    output logic [L2_DATA_W-1:0]         mem_wdata_o,
    input  logic [L2_DATA_W-1:0]         mem_rdata_i
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam int unsigned CW        = $clog2(RESP_DEPTH + 1);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'(L2_WORD_BYTES);

    logic [CW-1:0]        cnt;
    logic [L2_ADDR_W-1:0] off;
    logic                 in_range;
    logic                 pop;
    logic                 gnt;
    logic                 strobe;

    logic                 pend_valid;
    logic                 pend_we;
    logic                 pend_err;
    l2_resp_t             resp_c;

    l2_resp_t             head;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Grant while a credit is free, or when the head leaves in this same cycle.
    always_comb begin
        off      = bus.addr_i - BASE_ADDR;
        in_range = ({1'b0, off} < MEM_BYTES);
        pop      = !fifo_empty && bus.r_ready_i;
        gnt      = rst_n && bus.req_i && ((cnt < CW'(RESP_DEPTH)) || pop);
        strobe   = gnt && in_range;
    end

    // SRAM strobes live only in the grant cycle; everything idles at zero otherwise.
    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (strobe) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = !bus.we_i;
            mem_addr_o  = off[AW+1:2];
            mem_be_o    = l2_strobe_be(bus.we_i, bus.be_i);
            mem_wdata_o = bus.wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_err   <= 1'b0;
        end else begin
            pend_valid <= gnt;
            if (gnt) begin
                pend_we  <= bus.we_i;
                pend_err <= !in_range;
            end
        end
    end

    // SRAM data is only meaningful for an in-range read.
    always_comb begin
        resp_c.err   = pend_err;
        resp_c.rdata = (!pend_we && !pend_err) ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(gnt) - CW'(pop);
        end
    end

    jtag_l2_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (pend_valid),
        .push_data (resp_c),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.gnt_o     = gnt;
    assign bus.r_valid_o = !fifo_empty;
    assign bus.r_rdata_o = head.rdata;
    assign bus.r_err_o   = head.err;

    cnt_bound_a: assert property (@(posedge clk_i) disable iff (!rst_n) cnt <= CW'(RESP_DEPTH));

endmodule

// File: tb/tb_jtag_l2_mem_bridge.sv
// Scoreboard bench for jtag_l2_mem_bridge with a behavioural 1-cycle-latency SRAM.
module tb_jtag_l2_mem_bridge;
    import jtag_l2_pkg::*;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned WORDS = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = $clog2(WORDS);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtag_l2_mem_bridge_if bus ();

    logic          mem_csn;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    jtag_l2_mem_bridge #(
        .BASE_ADDR  (BASE),
        .MEM_WORDS  (WORDS),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mem_csn_o   (mem_csn),
        .mem_wen_o   (mem_wen),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Behavioural single-port SRAM, read data one cycle after the strobe.
    logic [31:0] sram [WORDS];
    always @(posedge clk) begin
        if (!mem_csn) begin
            if (!mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_grants = 0;
    int          n_pops = 0;
    int          last_gnt_cyc = 0;
    int          last_pop_cyc = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    l2_resp_t    sb_q [$];
    logic [31:0] shadow [WORDS];
    logic        hold_valid = 1'b0;
    l2_resp_t    hold_resp;
    l2_resp_t    exp_resp;
    l2_resp_t    got_resp;
    logic [31:0] m_off;
    logic        m_inr;
    logic [AW-1:0] m_idx;
    logic [AW+37:0] exp_strb;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard: expectations pushed at grant, compared at pop.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            hold_valid = 1'b0;
        end else begin
            got_resp = '{err: bus.r_err_o, rdata: bus.r_rdata_o};
            if (bus.req_i && bus.gnt_o) begin
                m_off = bus.addr_i - BASE;
                m_inr = (m_off < WORDS * 4);
                m_idx = m_off[AW+1:2];
                checks++;
                if (m_inr) begin
                    exp_strb = {1'b0, !bus.we_i, m_idx, (bus.we_i ? bus.be_i : 4'hF), bus.wdata_i};
                    if ({mem_csn, mem_wen, mem_addr, mem_be, mem_wdata} !== exp_strb) begin
                        failures++;
                        $display("FAIL strobe got=%h exp=%h", {mem_csn, mem_wen, mem_addr, mem_be, mem_wdata}, exp_strb);
                    end
                end else if ({mem_csn, mem_wen} !== 2'b11) begin
                    failures++;
                    $display("FAIL oor_strobe csn/wen got=%b exp=11", {mem_csn, mem_wen});
                end
                exp_resp.err   = !m_inr;
                exp_resp.rdata = (m_inr && !bus.we_i) ? shadow[m_idx] : 32'h0;
                sb_q.push_back(exp_resp);
                if (m_inr && bus.we_i)
                    for (int b = 0; b < 4; b++)
                        if (bus.be_i[b]) shadow[m_idx][8*b +: 8] = bus.wdata_i[8*b +: 8];
                n_grants++;
                last_gnt_cyc = cyc;
            end else begin
                checks++;
                if ({mem_csn, mem_wen} !== 2'b11) begin
                    failures++;
                    $display("FAIL idle_strobe csn/wen got=%b exp=11", {mem_csn, mem_wen});
                end
            end
            if (hold_valid) begin
                checks++;
                if (bus.r_valid_o !== 1'b1 || got_resp !== hold_resp) begin
                    failures++;
                    $display("FAIL stable valid=%b got=%h exp=%h", bus.r_valid_o, got_resp, hold_resp);
                end
            end
            if (bus.r_valid_o && bus.r_ready_i) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp got=%h exp=none", got_resp);
                end else begin
                    exp_resp = sb_q.pop_front();
                    if (got_resp !== exp_resp) begin
                        failures++;
                        $display("FAIL resp got=%h exp=%h", got_resp, exp_resp);
                    end
                end
                n_pops++;
                last_pop_cyc = cyc;
                last_rdata   = bus.r_rdata_o;
                last_err     = bus.r_err_o;
                hold_valid   = 1'b0;
            end else if (bus.r_valid_o) begin
                hold_valid = 1'b1;
                hold_resp  = got_resp;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        logic got;
        got = 1'b0;
        bus.req_i = 1'b1; bus.addr_i = a; bus.we_i = w; bus.be_i = b; bus.wdata_i = d;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.gnt_o) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL grant_timeout addr=%h got=0 exp=1", a); end
        @(posedge clk); #1;
        bus.req_i = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        bus.r_ready_i = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0 && !bus.r_valid_o) begin done = 1'b1; break; end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL drain_timeout pending=%0d exp=0", sb_q.size()); end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.gnt_o !== 1'b0) begin failures++; $display("FAIL %s_gnt got=%b exp=0", tag, bus.gnt_o); end
        checks++;
        if ({bus.r_valid_o, bus.r_err_o, bus.r_rdata_o} !== 34'h0) begin
            failures++; $display("FAIL %s_resp got=%h exp=0", tag, {bus.r_valid_o, bus.r_err_o, bus.r_rdata_o});
        end
        checks++;
        if ({mem_csn, mem_wen, mem_addr, mem_be, mem_wdata} !== {2'b11, {(AW+36){1'b0}}}) begin
            failures++; $display("FAIL %s_mem got=%h exp=%h", tag, {mem_csn, mem_wen, mem_addr, mem_be, mem_wdata}, {2'b11, {(AW+36){1'b0}}});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_i = 1'b1; bus.addr_i = BASE; bus.we_i = 1'b1; bus.be_i = 4'hF;
        bus.wdata_i = 32'hFFFF_FFFF; bus.r_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        bus.req_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int p0;
        p0 = n_pops;
        issue(BASE, 1'b1, 4'hF, 32'hABBA_ABBA);
        issue(BASE, 1'b0, 4'hF, 32'h0);
        drain();
        checks++;
        if (n_pops - p0 != 2) begin failures++; $display("FAIL wr_rd_count got=%0d exp=2", n_pops - p0); end
        checks++;
        if (last_rdata !== 32'hABBA_ABBA || last_err !== 1'b0) begin
            failures++; $display("FAIL wr_rd_data got=%h/%b exp=abbaabba/0", last_rdata, last_err);
        end
        checks++;
        if (last_pop_cyc - last_gnt_cyc != 2) begin
            failures++; $display("FAIL latency got=%0d exp=2", last_pop_cyc - last_gnt_cyc);
        end
    endtask

    task automatic test_partial_write();
        issue(BASE + 32'h4, 1'b1, 4'hF, 32'h1122_3344);
        issue(BASE + 32'h4, 1'b1, 4'b0101, 32'hAABB_CCDD);
        issue(BASE + 32'h4, 1'b0, 4'hF, 32'h0);
        drain();
        checks++;
        if (last_rdata !== 32'h11BB_33DD) begin failures++; $display("FAIL partial got=%h exp=11bb33dd", last_rdata); end
    endtask

    task automatic test_out_of_range();
        issue(BASE + WORDS * 4, 1'b0, 4'hF, 32'h0);
        drain();
        checks++;
        if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
            failures++; $display("FAIL oor_high got=%b/%h exp=1/0", last_err, last_rdata);
        end
        issue(BASE - 32'h4, 1'b0, 4'hF, 32'h0);
        drain();
        checks++;
        if (last_err !== 1'b1) begin failures++; $display("FAIL oor_below got=%b exp=1", last_err); end
        issue(BASE + WORDS * 4, 1'b1, 4'hF, 32'hDEAD_BEEF);
        issue(BASE, 1'b0, 4'hF, 32'h0);
        drain();
        checks++;
        if (last_rdata !== 32'hABBA_ABBA || last_err !== 1'b0) begin
            failures++; $display("FAIL oor_no_touch got=%h exp=abbaabba", last_rdata);
        end
    endtask

    // Holds req for three reads with r_ready low; returns the number of grants seen.
    task automatic blocked_burst(input logic [31:0] a0, output int granted);
        int idx;
        idx = 0;
        granted = 0;
        bus.r_ready_i = 1'b0;
        bus.req_i = 1'b1; bus.addr_i = a0; bus.we_i = 1'b0; bus.be_i = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.gnt_o) begin idx++; granted++; end
            @(posedge clk); #1;
            bus.addr_i = a0 + 32'(4 * (idx < 3 ? idx : 2));
        end
    endtask

    task automatic test_backpressure();
        int g;
        int g0;
        issue(BASE + 32'h10, 1'b1, 4'hF, 32'h0000_00A0);
        issue(BASE + 32'h14, 1'b1, 4'hF, 32'h0000_00A1);
        issue(BASE + 32'h18, 1'b1, 4'hF, 32'h0000_00A2);
        drain();
        g0 = n_grants;
        blocked_burst(BASE + 32'h10, g);
        checks++;
        if (g != DEPTH) begin failures++; $display("FAIL bp_grants got=%0d exp=%0d", g, DEPTH); end
        checks++;
        if (bus.gnt_o !== 1'b0 || bus.r_valid_o !== 1'b1) begin
            failures++; $display("FAIL bp_stall gnt/valid got=%b%b exp=01", bus.gnt_o, bus.r_valid_o);
        end
        bus.r_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt_o !== 1'b1) begin failures++; $display("FAIL grant_with_pop got=%b exp=1", bus.gnt_o); end
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        drain();
        checks++;
        if (n_grants - g0 != 3 || last_rdata !== 32'h0000_00A2) begin
            failures++; $display("FAIL bp_order grants=%0d last=%h exp=3/000000a2", n_grants - g0, last_rdata);
        end
    endtask

    task automatic test_streaming();
        int g0;
        int p0;
        int first;
        for (int i = 0; i < 16; i++)
            issue(BASE + 32'(4 * i), 1'b1, 4'hF, 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101));
        g0 = n_grants;
        p0 = n_pops;
        bus.r_ready_i = 1'b1;
        issue(BASE, 1'b0, 4'hF, 32'h0);
        first = last_gnt_cyc;
        for (int i = 1; i < 16; i++)
            issue(BASE + 32'(4 * i), 1'b0, 4'hF, 32'h0);
        checks++;
        if (last_gnt_cyc - first != 15 || n_grants - g0 != 16) begin
            failures++; $display("FAIL stream_rate span=%0d grants=%0d exp=15/16", last_gnt_cyc - first, n_grants - g0);
        end
        drain();
        checks++;
        if (last_rdata !== (32'h5A00_0000 ^ 32'h0F0F_0F0F)) begin
            failures++; $display("FAIL stream_last got=%h exp=%h", last_rdata, 32'h5A00_0000 ^ 32'h0F0F_0F0F);
        end
        checks++;
        if (n_pops - p0 < 16) begin failures++; $display("FAIL stream_pops got=%0d exp=16", n_pops - p0); end
    endtask

    task automatic test_reset_midflight();
        int g;
        bus.r_ready_i = 1'b0;
        issue(BASE + 32'h20, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h24, 1'b0, 4'hF, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (bus.r_valid_o !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", bus.r_valid_o); end
        bus.req_i = 1'b1; bus.addr_i = BASE; bus.we_i = 1'b1; bus.be_i = 4'hF; bus.wdata_i = 32'h1234_5678;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        bus.req_i = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        blocked_burst(BASE + 32'h10, g);
        checks++;
        if (g != DEPTH) begin failures++; $display("FAIL post_reset_credits got=%0d exp=%0d", g, DEPTH); end
        bus.req_i = 1'b0;
        drain();
        issue(BASE + 32'h8, 1'b1, 4'hF, 32'h600D_F00D);
        issue(BASE + 32'h8, 1'b0, 4'hF, 32'h0);
        drain();
        checks++;
        if (last_rdata !== 32'h600D_F00D || last_err !== 1'b0) begin
            failures++; $display("FAIL post_reset_rw got=%h exp=600df00d", last_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_backpressure();
        test_streaming();
        test_reset_midflight();
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL leftover got=%0d exp=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
